conv_result_streamer: RTL

- Downstream of the convolution control unit.
- Once a convolution pass completes, drains the output result memory and presents each result on a valid/ready stream.
- Output order is addresses 0..N-1, where N = (I-K+1)^2.
- Hides the memory's 1-cycle read latency behind a 2-entry buffer, so back-to-back transfers run at full rate under any backpressure pattern.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_skid_fifo.sv | 63 ++++++
 rtl/conv_result_streamer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution result streamer.
// Optional build macro used by the streamer: CONV_RELU_EN.
package conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int I_W_DEF    = 10;
    localparam int K_W_DEF    = 3;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        ERR
    } state_t;

    // Number of valid output positions: (I-K+1)^2. Only meaningful when size_ok().
    function automatic logic [63:0] out_count(input logic [31:0] i, input logic [31:0] k);
        logic [63:0] side;
        side = {32'd0, i} - {32'd0, k} + 64'd1;
        return side * side;
    endfunction

    // A kernel must be non-empty and fit inside the image.
    function automatic logic size_ok(input logic [31:0] i, input logic [31:0] k);
        return (k != 32'd0) && (k <= i);
    endfunction

endpackage

// File: rtl/conv_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs the memory's read latency.
// Push and pop in the same cycle leave occupancy unchanged.
module conv_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_push, do_pop;

    // Pointer/occupancy update; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != 2'd0);
        do_push  = push && ((cnt_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (cnt_q == 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/conv_result_streamer.sv
// Drains the convolution output memory (addresses 0..N-1, N=(I-K+1)^2) onto a
// valid/ready stream at full rate. Define CONV_RELU_EN to clamp negative
// results to zero on the stream output.
module conv_result_streamer
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int I_W    = I_W_DEF,
    parameter int K_W    = K_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [I_W-1:0]    I,
    input  logic [K_W-1:0]    K,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              finished,
    output logic              size_err
);

    localparam int CNT_W = ADDR_W + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               size_err_q, size_err_d;
    logic               rd_pend_q, rd_pend_d;   // read issued last cycle, data arrives now

    logic               pop;
    logic               fifo_empty;
    logic [1:0]         fifo_count;
    logic [DATA_W-1:0]  head;
    logic [2:0]         occ;

    conv_skid_fifo #(.W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rd_pend_q),
        .push_data (rd_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Control FSM: sizing on start, credit-limited reads, completion tracking.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rd_cnt_d   = rd_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        size_err_d = size_err_q;
        rd_en      = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        pop        = !fifo_empty && m_ready;
        // Slots committed after this cycle's pop; counting the pop keeps reads back-to-back.
        occ        = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, pop};

        if (pop) begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d        = CNT_W'(out_count(32'(I), 32'(K)));
                    rd_cnt_d   = '0;
                    tx_cnt_d   = '0;
                    size_err_d = !size_ok(32'(I), 32'(K));
                    state_d    = size_ok(32'(I), 32'(K)) ? STREAM : ERR;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (rd_cnt_q == n_q) begin
                    state_d = DRAIN;
                end else if (occ < 3'd2) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (tx_cnt_q == n_q) begin
                    finished = 1'b1;
                    state_d  = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            ERR: begin
                finished = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rd_pend_d = rd_en;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            size_err_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            size_err_q <= size_err_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    assign rd_addr  = rd_cnt_q[ADDR_W-1:0];
    assign m_valid  = !fifo_empty;
    assign m_last   = m_valid && (tx_cnt_q == n_q - CNT_W'(1));
    assign size_err = size_err_q;

    // Stream data straight from the buffer head, optionally clamped at zero.
    always_comb begin
`ifdef CONV_RELU_EN
        m_data = head[DATA_W-1] ? '0 : head;
`else
        m_data = head;
`endif
    end

endmodule
